aes_round_sequencer: RTL
========================

Name: aes_round_sequencer

Overview:
Top-level controller for the iterative AES-128 round engine (one 20-cycle round per enable pulse, with on-the-fly key expansion). It accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then issues rounds 0..9 to the engine, holding its text and key inputs stable, and captures the engine's per-round text and round key. It returns the ciphertext over a valid/ready handshake and flags engine hangs with a watchdog.

Parameters:
NUM_ROUNDS, 10, number of engine rounds issued; the final round index is NUM_ROUNDS-1.
TIMEOUT, 31, maximum WAIT cycles without rnd_done before error; must be greater than or equal to 20.

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  sequencer can accept
in_text  in  128  plaintext; byte i at [8i+7:8i]
in_key  in  128  cipher key; same byte order
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
out_text  out  128  ciphertext
busy  out  1  high in any state other than IDLE
err  out  1  sticky watchdog error; cleared on next accept
rnd_enable  out  1  one-cycle round start to engine
rnd_round  out  4  round index 0..9 to engine
rnd_text  out  128  engine text input (state_q)
rnd_key  out  128  engine key input (key_q)
rnd_done  in  1  engine round-complete strobe (engine counter = 19)
rnd_o_text  in  128  engine registered round output
rnd_rkey  in  128  engine registered next round key

Behaviour:
- Reset (async, resetn=0). State = IDLE.
  - state_q, key_q, out_text and rnd_round are 0.
  - rnd_enable, out_valid, busy and err are 0.
- States: IDLE, ISSUE, WAIT, CAPTURE, OUT.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
- Accept (in_valid & in_ready on an edge):
  - state_q <= in_text ^ in_key; key_q <= in_key.
  - rnd_round <= 0; err <= 0; next state = ISSUE.
- ISSUE: rnd_enable=1 for exactly this cycle, then WAIT. Clear the watchdog count.
- WAIT: rnd_enable=0.
  - On rnd_done=1, go to CAPTURE.
  - Otherwise increment the watchdog. If the watchdog reaches TIMEOUT: err <= 1, go to IDLE, and out_valid is not raised.
- CAPTURE: state_q <= rnd_o_text; key_q <= rnd_rkey.
  - If rnd_round == NUM_ROUNDS-1, go to OUT and out_text <= rnd_o_text.
  - Otherwise rnd_round <= rnd_round+1 and go to ISSUE.
- OUT: out_valid=1. out_text is held stable until out_valid & out_ready.
  - On handshake with a simultaneous accept: load the new job and go to ISSUE; out_valid drops next cycle.
  - On handshake without an accept: go to IDLE.
- rnd_text and rnd_key are driven from state_q and key_q. They change only at the accept edge and the CAPTURE edge, so they are stable for the engine's whole 20-cycle round.
- rnd_done outside WAIT is ignored. The engine's reset-value Rkey is never used; key_q is the only key source.
- Cycle timing per round: ISSUE (1 cycle) + WAIT (19 cycles, engine counter 1..19) + CAPTURE (1 cycle) = 21 cycles.
- Overall latency: first out_valid cycle is the 211th cycle after the accept edge.
- in_valid while busy (and not in OUT with out_ready) is back-pressured: in_ready=0 and the inputs are not sampled.
- Reset mid-operation: everything returns to reset values immediately. The engine's synchronous reset clears its counter on the next edge.

Decomposition:
- aes_pkg holds:
  - the seq_state_t enum (IDLE, ISSUE, WAIT, CAPTURE, OUT);
  - ROUND_CYCLES=20;
  - LAST_ROUND=4'd9;
  - the 4-bit round index type.
- One natural sub-module: aes_seq_watchdog, a clearable counter with a terminal flag. All other logic stays in the FSM.
- The top-level test harness instantiates the sequencer alongside the round engine.

Test Plan:
- FIPS-197 C.1 vector with engine attached:
  - in_key=128'h0f0e0d0c0b0a09080706050403020100, in_text=128'hffeeddccbbaa99887766554433221100;
  - expect out_text=128'h5ac5b47080b7cdd830047b6ad8e0c469 with out_valid in the 211th cycle after accept.
- Round sequencing:
  - rnd_enable pulses exactly 10 times, each one cycle wide, 21 cycles apart;
  - rnd_round steps 0..9;
  - rnd_text/rnd_key are unchanged during each WAIT.
- Back-pressure:
  - hold out_ready=0 for 50 cycles → out_valid stays 1, out_text constant, in_ready=0;
  - in_valid asserted during the run is not accepted.
- Back-to-back: in_valid=1 and out_ready=1 in the first OUT cycle → second job accepted the same edge, ISSUE next cycle, and the second ciphertext is correct.
- Watchdog: replace the engine with a stub that never asserts rnd_done → err=1 after 31 WAIT cycles, FSM in IDLE, out_valid never 1; the next accept clears err.
- Async reset: drop resetn in round 5 → outputs go to reset values without waiting for an edge; a subsequent job completes with the correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg: shared state, round-index and timing definitions. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    OUT     = 3'd4
  } seq_state_t;

  typedef logic [3:0] round_idx_t;

  localparam int         ROUND_CYCLES = 20;
  localparam round_idx_t LAST_ROUND   = 4'd9;

endpackage

`default_nettype wire

// File: rtl/aes_seq_watchdog.sv
// ---------------------------------------------------------------------------
// aes_seq_watchdog: clearable up-counter flagging its final allowed count. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_seq_watchdog #(
  parameter int TIMEOUT = 31
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic inc,
  output logic term
);

  localparam int           W        = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] TERM_CNT = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  // term marks the TIMEOUT-th counted cycle, so the caller can bail out on it
  assign term = (count == TERM_CNT);

endmodule

`default_nettype wire

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer: drives the iterative AES-128 round engine through all
// rounds of one block, with handshaked I/O and a hang watchdog. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = int'(LAST_ROUND) + 1,
  parameter int TIMEOUT    = 31
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy,
  output logic         err,
  output logic         rnd_enable,
  output logic [3:0]   rnd_round,
  output logic [127:0] rnd_text,
  output logic [127:0] rnd_key,
  input  logic         rnd_done,
  input  logic [127:0] rnd_o_text,
  input  logic [127:0] rnd_rkey
);

  localparam round_idx_t FINAL_ROUND = round_idx_t'(NUM_ROUNDS - 1);

  if (TIMEOUT < ROUND_CYCLES) begin : g_bad_timeout
    $error("aes_round_sequencer: TIMEOUT shorter than one engine round");
  end

  seq_state_t   state, next_state;
  logic [127:0] state_q, key_q;
  logic         accept, capture, timeout, last_round;
  logic         wd_clear, wd_inc, wd_term;

  aes_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .resetn (resetn),
    .clear  (wd_clear),
    .inc    (wd_inc),
    .term   (wd_term)
  );

  assign last_round = (rnd_round == FINAL_ROUND);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rnd_enable = 1'b0;
    wd_clear   = 1'b0;
    wd_inc     = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        rnd_enable = 1'b1;
        wd_clear   = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (rnd_done) begin
          next_state = CAPTURE;
        end else begin
          wd_inc = 1'b1;
          if (wd_term) begin
            timeout    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        next_state = last_round ? OUT : ISSUE;
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // a new job may be loaded on the very edge the old result leaves
        if (out_ready) begin
          if (in_valid) begin
            accept     = 1'b1;
            next_state = ISSUE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // engine inputs only move on accept and capture, never mid-round
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= '0;
      key_q     <= '0;
      out_text  <= '0;
      rnd_round <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        state_q   <= in_text ^ in_key;
        key_q     <= in_key;
        rnd_round <= '0;
        err       <= 1'b0;
      end else if (capture) begin
        state_q <= rnd_o_text;
        key_q   <= rnd_rkey;
        if (last_round) begin
          out_text <= rnd_o_text;
        end else begin
          rnd_round <= rnd_round + 4'd1;
        end
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign rnd_text = state_q;
  assign rnd_key  = key_q;

endmodule

`default_nettype wire
